// File: rtl/clk_meas_pkg.sv
// Shared types and defaults for the slow-clock period meter and its helpers.
package clk_meas_pkg;

   localparam int DEF_WIDTH      = 32;
   localparam int DEF_TIMEOUT    = 2**24;
   localparam int DEF_LOCK_COUNT = 4;

   // Cycles after reset release before the synchronizer output reflects sig_in.
   localparam int SETTLE_CYCLES  = 2;

   typedef enum logic [2:0] {
      SEARCH,
      ARM,
      HIGH,
      LOW,
      STALL
   } meas_state_e;

endpackage

// File: rtl/sig_sync_edge.sv
// Two-flop synchronizer for an asynchronous level plus rise/fall detection
// against a one-cycle history of the synchronized value.
module sig_sync_edge (
   input  logic inclk,
   input  logic Reset,
   input  logic sig_in,
   output logic s,
   output logic rise,
   output logic fall
);

   logic meta_q;
   logic sync_q;
   logic hist_q;

   // NOTE: non-blocking assignments make the three flops shift as one chain;
   // blocking ones would collapse the synchronizer into a single stage.
   always_ff @(posedge inclk or negedge Reset) begin
      if (!Reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         hist_q <= 1'b0;
      end else begin
         meta_q <= sig_in;
         sync_q <= meta_q;
         hist_q <= sync_q;
      end
   end

   assign s    = sync_q;
   assign rise =  sync_q & ~hist_q;
   assign fall = ~sync_q &  hist_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures high, low and full-period lengths of a slow asynchronous square
// wave in inclk cycles, with lock detection and stall timeout.
module clk_period_meter
   import clk_meas_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int TIMEOUT    = DEF_TIMEOUT,
   parameter int LOCK_COUNT = DEF_LOCK_COUNT
) (
   input  logic             inclk,
   input  logic             Reset,
   input  logic             sig_in,
   output logic [WIDTH-1:0] high_count,
   output logic [WIDTH-1:0] low_count,
   output logic [WIDTH-1:0] period_count,
   output logic             meas_valid,
   output logic             locked,
   output logic             timeout
);

   localparam int MW = $clog2(LOCK_COUNT);
   localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);
   localparam logic [WIDTH-1:0] SETTLE_W  = WIDTH'(SETTLE_CYCLES);
   localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);
   localparam logic [MW-1:0]    MATCH_MAX = MW'(LOCK_COUNT - 1);

   logic s;
   logic rise;
   logic fall;

   sig_sync_edge u_sync (
      .inclk  (inclk),
      .Reset  (Reset),
      .sig_in (sig_in),
      .s      (s),
      .rise   (rise),
      .fall   (fall)
   );

   meas_state_e      state_q;
   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] high_len_q;
   logic [WIDTH-1:0] prev_period_q;
   logic             prev_valid_q;
   logic [MW-1:0]    match_q;
   logic [WIDTH-1:0] high_count_q;
   logic [WIDTH-1:0] low_count_q;
   logic [WIDTH-1:0] period_count_q;
   logic             meas_valid_q;
   logic             locked_q;
   logic             timeout_q;

   logic [WIDTH-1:0] cnt_d;
   logic [WIDTH-1:0] period_d;
   logic [MW-1:0]    match_d;
   logic             at_timeout;

   // NOTE: every always_comb output gets a default before any branch, so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      at_timeout = (cnt_q == TIMEOUT_W);
      cnt_d      = at_timeout ? cnt_q : cnt_q + ONE_W;
      period_d   = high_len_q + cnt_q;
      match_d    = '0;
      if (prev_valid_q && (period_d == prev_period_q)) begin
         match_d = (match_q == MATCH_MAX) ? match_q : match_q + MW'(1);
      end
   end

   always_ff @(posedge inclk or negedge Reset) begin
      if (!Reset) begin
         state_q        <= SEARCH;
         cnt_q          <= '0;
         high_len_q     <= '0;
         prev_period_q  <= '0;
         prev_valid_q   <= 1'b0;
         match_q        <= '0;
         high_count_q   <= '0;
         low_count_q    <= '0;
         period_count_q <= '0;
         meas_valid_q   <= 1'b0;
         locked_q       <= 1'b0;
         timeout_q      <= 1'b0;
      end else begin
         meas_valid_q <= 1'b0;
         cnt_q        <= cnt_d;

         unique case (state_q)
            // The synchronizer resets to 0, so s is only trusted once the
            // settle window has passed; otherwise a high sig_in at release
            // would look like a rise and yield a partial first phase.
            SEARCH: begin
               if ((cnt_q >= SETTLE_W) && !s) begin
                  state_q <= ARM;
               end
            end

            ARM: begin
               if (rise) begin
                  state_q <= HIGH;
                  cnt_q   <= ONE_W;
               end
            end

            HIGH: begin
               if (fall) begin
                  high_len_q <= cnt_q;
                  cnt_q      <= ONE_W;
                  state_q    <= LOW;
               end else if (at_timeout) begin
                  state_q      <= STALL;
                  timeout_q    <= 1'b1;
                  locked_q     <= 1'b0;
                  match_q      <= '0;
                  prev_valid_q <= 1'b0;
               end
            end

            LOW: begin
               if (rise) begin
                  state_q        <= HIGH;
                  cnt_q          <= ONE_W;
                  high_count_q   <= high_len_q;
                  low_count_q    <= cnt_q;
                  period_count_q <= period_d;
                  meas_valid_q   <= 1'b1;
                  prev_period_q  <= period_d;
                  prev_valid_q   <= 1'b1;
                  match_q        <= match_d;
                  locked_q       <= (match_d == MATCH_MAX);
               end else if (at_timeout) begin
                  state_q      <= STALL;
                  timeout_q    <= 1'b1;
                  locked_q     <= 1'b0;
                  match_q      <= '0;
                  prev_valid_q <= 1'b0;
               end
            end

            STALL: begin
               if (rise) begin
                  timeout_q <= 1'b0;
                  state_q   <= HIGH;
                  cnt_q     <= ONE_W;
               end
            end

            default: begin
               state_q <= SEARCH;
            end
         endcase
      end
   end

   assign high_count   = high_count_q;
   assign low_count    = low_count_q;
   assign period_count = period_count_q;
   assign meas_valid   = meas_valid_q;
   assign locked       = locked_q;
   assign timeout      = timeout_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: divider-like patterns, lock loss and
// relock, stall timeout, and reset behaviour, with hand-computed expectations.
module tb_clk_period_meter;

   localparam int W = 32;

   logic         inclk  = 1'b0;
   logic         Reset  = 1'b0;
   logic         sig_in = 1'b0;
   logic [W-1:0] high_count;
   logic [W-1:0] low_count;
   logic [W-1:0] period_count;
   logic         meas_valid;
   logic         locked;
   logic         timeout;

   typedef struct {
      longint h;
      longint l;
      longint p;
      longint lk;
      longint cyc;
   } mv_t;

   mv_t    mv_q[$];
   longint cyc      = 0;
   int     n_checks = 0;
   int     n_errors = 0;

   clk_period_meter #(
      .WIDTH      (W),
      .TIMEOUT    (64),
      .LOCK_COUNT (4)
   ) dut (
      .inclk        (inclk),
      .Reset        (Reset),
      .sig_in       (sig_in),
      .high_count   (high_count),
      .low_count    (low_count),
      .period_count (period_count),
      .meas_valid   (meas_valid),
      .locked       (locked),
      .timeout      (timeout)
   );

   always #5 inclk = ~inclk;

   always @(posedge inclk) cyc <= cyc + 1;

   always @(negedge inclk) begin
      if (meas_valid === 1'b1) begin
         mv_t e;
         e.h   = longint'(high_count);
         e.l   = longint'(low_count);
         e.p   = longint'(period_count);
         e.lk  = longint'(locked);
         e.cyc = cyc;
         mv_q.push_back(e);
      end
   end

   task automatic check(input string tag, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge inclk);
      #1;
   endtask

   task automatic drive(input int hi, input int lo, input int n);
      repeat (n) begin
         sig_in = 1'b1;
         repeat (hi) tick();
         sig_in = 1'b0;
         repeat (lo) tick();
      end
   endtask

   task automatic do_reset(input logic lvl);
      sig_in = lvl;
      Reset  = 1'b0;
      repeat (3) tick();
      Reset = 1'b1;
      repeat (5) tick();
      mv_q.delete();
   endtask

   task automatic chk_mv(input string tag, input int idx, input longint h,
                         input longint l, input longint p, input longint lk);
      if (idx < mv_q.size()) begin
         check({tag, "_high"},   mv_q[idx].h,  h);
         check({tag, "_low"},    mv_q[idx].l,  l);
         check({tag, "_period"}, mv_q[idx].p,  p);
         check({tag, "_locked"}, mv_q[idx].lk, lk);
      end else begin
         check({tag, "_present"}, longint'(mv_q.size()), longint'(idx + 1));
      end
   endtask

   task automatic chk_lock(input string tag, input int idx, input longint lk);
      if (idx < mv_q.size()) begin
         check(tag, mv_q[idx].lk, lk);
      end else begin
         check({tag, "_present"}, longint'(mv_q.size()), longint'(idx + 1));
      end
   endtask

   initial begin
      // Reset state while Reset is held low
      repeat (2) tick();
      check("rst_high",    longint'(high_count),   0);
      check("rst_low",     longint'(low_count),    0);
      check("rst_period",  longint'(period_count), 0);
      check("rst_valid",   longint'(meas_valid),   0);
      check("rst_locked",  longint'(locked),       0);
      check("rst_timeout", longint'(timeout),      0);

      // Divide-by-4 source, then switch to divide-by-6, then stall
      do_reset(1'b0);
      drive(4, 4, 6);
      drive(6, 6, 5);
      chk_mv("div4_first", 0, 4, 4, 8, 0);
      chk_lock("div4_lock3", 2, 0);
      chk_lock("div4_lock4", 3, 1);
      if (mv_q.size() >= 2) begin
         check("div4_spacing", mv_q[1].cyc - mv_q[0].cyc, 8);
      end else begin
         check("div4_spacing_present", longint'(mv_q.size()), 2);
      end
      chk_mv("div6_first", 6, 6, 6, 12, 0);
      chk_lock("div6_lock3", 8, 0);
      chk_lock("div6_lock4", 9, 1);

      sig_in = 1'b1;
      repeat (6) tick();
      sig_in = 1'b0;
      repeat (66) tick();
      check("mv_count_a", longint'(mv_q.size()), 11);
      check("stall_pre_timeout", longint'(timeout), 0);
      check("stall_pre_locked",  longint'(locked),  1);
      tick();
      check("stall_timeout", longint'(timeout),      1);
      check("stall_locked",  longint'(locked),       0);
      check("stall_high",    longint'(high_count),   6);
      check("stall_period",  longint'(period_count), 12);

      sig_in = 1'b1;
      repeat (2) tick();
      check("resume_pre_rise", longint'(timeout), 1);
      tick();
      check("resume_rise", longint'(timeout), 0);
      tick();
      sig_in = 1'b0;
      repeat (4) tick();
      drive(4, 4, 2);
      drive(4, 4, 1);
      check("mv_count_resume", longint'(mv_q.size()), 14);
      chk_mv("resume_first", 11, 4, 4, 8, 0);
      chk_lock("resume_second", 12, 0);

      // High 3 / low 5 pattern
      do_reset(1'b0);
      drive(3, 5, 6);
      chk_mv("h3l5_first", 0, 3, 5, 8, 0);
      chk_lock("h3l5_lock3", 2, 0);
      chk_lock("h3l5_lock4", 3, 1);

      // Reset released while sig_in is high
      do_reset(1'b1);
      repeat (5) tick();
      check("rsthi_no_mv_high", longint'(mv_q.size()), 0);
      sig_in = 1'b0;
      repeat (5) tick();
      check("rsthi_no_mv_low", longint'(mv_q.size()), 0);
      drive(4, 4, 3);
      check("rsthi_mv_count", longint'(mv_q.size()), 2);
      chk_mv("rsthi_first", 0, 4, 4, 8, 0);

      // Reset asserted in the middle of a high phase
      do_reset(1'b0);
      drive(4, 4, 3);
      sig_in = 1'b1;
      repeat (5) tick();
      check("mid_pre_high", longint'(high_count), 4);
      Reset = 1'b0;
      #1;
      check("mid_high",    longint'(high_count),   0);
      check("mid_low",     longint'(low_count),    0);
      check("mid_period",  longint'(period_count), 0);
      check("mid_valid",   longint'(meas_valid),   0);
      check("mid_locked",  longint'(locked),       0);
      check("mid_timeout", longint'(timeout),      0);
      tick();
      Reset = 1'b1;
      mv_q.delete();
      repeat (6) tick();
      sig_in = 1'b0;
      repeat (12) tick();
      check("mid_no_spurious", longint'(mv_q.size()), 0);
      drive(5, 3, 3);
      chk_mv("mid_after", 0, 5, 3, 8, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
Measures a slow, divided or otherwise asynchronous square wave, using the system clock as the timebase. It reports the high-phase, low-phase and full-period lengths in inclk cycles, and flags lock and stall conditions. This is the receive-side counterpart of the team's clock divider: fed with the divider's output, it recovers the divide count. It sits beside the divider for self-check and can serve any on-board slow-clock monitor.

Parameters:
WIDTH, 32, width of all count outputs and of the internal counter
TIMEOUT, 2**24, inclk cycles without a synchronized edge before stall is declared; must be < 2**WIDTH
LOCK_COUNT, 4, consecutive identical period measurements required to assert locked (>=2)

Ports:
inclk  in  1  system clock, timebase for all counting
Reset  in  1  asynchronous, active-low reset
sig_in  in  1  signal to measure; asynchronous to inclk
high_count  out  WIDTH  inclk cycles sig was high in the last completed period
low_count  out  WIDTH  inclk cycles sig was low in the last completed period
period_count  out  WIDTH  high_count + low_count of the last completed period, truncated to WIDTH
meas_valid  out  1  one-cycle pulse when the three counts update
locked  out  1  high while the last LOCK_COUNT periods were identical
timeout  out  1  high while in STALL

Behaviour:
- Reset (Reset=0, async):
  - all outputs 0; state SEARCH; counter 0; match counter 0.
  - 2-flop synchronizer and edge-history register cleared to 0.
- Input conditioning:
  - sig_in passes through a 2-flop synchronizer, giving s.
  - rise = s & ~s_d; fall = ~s & s_d. Detection latency is 3 inclk cycles from the sig_in transition. The latency is constant, so measured lengths are exact for an inclk-synchronous source.
- Counter:
  - loads 1 on any cycle with a detected edge that the current state acts on;
  - otherwise increments, saturating at TIMEOUT.
- States:
  - SEARCH: wait for s==0, then go to ARM. This discards the partial phase present at reset release.
  - ARM: on rise, go to HIGH and load counter = 1.
  - HIGH: on fall, latch high_len = counter, load counter = 1, go to LOW.
  - LOW: on rise, go to HIGH, load counter = 1, and on the next edge register:
    - high_count <= high_len
    - low_count <= counter
    - period_count <= high_len + counter
    - meas_valid pulses in that same cycle.
  - In HIGH or LOW, counter == TIMEOUT with no edge: go to STALL, timeout <= 1, locked <= 0, match counter <= 0. Count outputs hold their last values.
  - STALL: on rise, timeout <= 0, go to HIGH with counter = 1. The first measurement after stall is published normally.
- Lock:
  - On each meas_valid, the new period is compared with the previously published period.
  - Equal: match counter increments, saturating at LOCK_COUNT-1.
  - Unequal: match counter resets to 0 and locked <= 0 in the same cycle as meas_valid.
  - locked <= 1 when the match counter reaches LOCK_COUNT-1, i.e. LOCK_COUNT equal periods.
  - The first measurement after reset or stall never counts as a match.
- Edges and phases:
  - rise and fall cannot occur in the same cycle (single-bit s).
  - Phases shorter than 1 cycle after synchronization are invisible. A high pulse that is lost merges into the low phase; this is documented and not flagged.
- Reset asserted mid-measurement: immediate return to reset values. No meas_valid is emitted for the partial period.

Decomposition:
- Package clk_meas_pkg:
  - state enum {SEARCH, ARM, HIGH, LOW, STALL}
  - default constants for WIDTH, TIMEOUT and LOCK_COUNT.
- Sub-module sig_sync_edge:
  - inputs inclk, Reset, sig_in
  - outputs s, rise, fall
  - 2-flop synchronizer plus edge-history register
  - reused by the team for other asynchronous inputs.

Test Plan:
- Drive sig_in from the clock divider, div_clk_count=4, same inclk.
  - Expected: high_count=4, low_count=4, period_count=8, meas_valid every 8 cycles.
  - locked rises on the 4th meas_valid.
- Pattern high 3 / low 5 cycles, repeating.
  - Expected: high_count=3, low_count=5, period_count=8, locked after 4 periods.
- Lock loss and relock: lock with N=4, then switch the divider to N=6.
  - First mismatched period: period_count=12 and locked=0 in the same cycle as meas_valid.
  - locked=1 again after 4 periods of 12.
- Stall, TIMEOUT=64: after lock, hold sig_in low.
  - Expected: timeout=1 and locked=0 exactly 64 cycles after the last detected fall; counts unchanged.
  - Resume toggling: timeout=0 on the first rise; valid counts reappear after one full period.
- Reset with sig_in high: release reset while sig_in=1.
  - Expected: no meas_valid until a fall, a rise, and one full period have occurred; first counts correct.
- Mid-measurement reset: assert Reset in the middle of a HIGH phase.
  - Expected: all outputs 0 asynchronously; no spurious meas_valid after release.
